// File: rtl/set_assoc_cache.sv
// ============================================================================
// Module  : set_assoc_cache
// Brief   : N-way set-associative write-through, no-write-allocate data cache
//           with LRU replacement, req/ack memory fill and whole-cache invalidate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module set_assoc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH  = 3,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_ready_o,
    output logic                  hit_o,
    input  logic                  inval_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;
    localparam int SETS      = 1 << SET_WIDTH;
    localparam int AGE_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [AGE_W-1:0] C_AGE_MAX = AGE_W'(WAYS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  inval_pend_q, inval_pend_d;

    logic                  valid_q [SETS][WAYS];
    logic [AGE_W-1:0]      age_q   [SETS][WAYS];
    logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

    logic [SET_WIDTH-1:0]  w_lk_set, w_fl_set, w_touch_set;
    logic [TAG_WIDTH-1:0]  w_lk_tag, w_fl_tag;
    logic [AGE_W-1:0]      w_lk_way, w_victim, w_touch_way, w_touch_age;
    logic                  w_lk_hit;
    logic                  w_touch_en, w_install_en, w_store_en, w_clear_all;
    logic                  w_unused_ok;

    assign w_unused_ok = ^cpu_addr_i[1:0];

    // Lookup for the CPU address; the fill target comes from the registered address.
    always_comb begin
        w_lk_set = cpu_addr_i[SET_WIDTH+1:2];
        w_lk_tag = cpu_addr_i[ADDR_WIDTH-1:SET_WIDTH+2];
        w_fl_set = mem_addr_q[SET_WIDTH+1:2];
        w_fl_tag = mem_addr_q[ADDR_WIDTH-1:SET_WIDTH+2];
        w_lk_hit = 1'b0;
        w_lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w_lk_set][w] && (tag_q[w_lk_set][w] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_way = AGE_W'(w);
            end
        end
        w_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[w_fl_set][w] == C_AGE_MAX) w_victim = AGE_W'(w);
        end
        // Descending scan so the lowest-index invalid way wins over the LRU way.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w_fl_set][w]) w_victim = AGE_W'(w);
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inval_pend_d = inval_pend_q;
        cpu_ready_o  = 1'b0;
        cpu_rdata_o  = '0;
        hit_o        = 1'b0;
        w_touch_en   = 1'b0;
        w_touch_set  = w_lk_set;
        w_touch_way  = w_lk_way;
        w_install_en = 1'b0;
        w_store_en   = 1'b0;
        w_clear_all  = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_clear_all = inval_i;
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = cpu_wdata_i;
                        state_d     = S_WRITE;
                        w_store_en  = w_lk_hit;
                        w_touch_en  = w_lk_hit;
                    end else if (w_lk_hit && !inval_i) begin
                        hit_o       = 1'b1;
                        cpu_ready_o = 1'b1;
                        cpu_rdata_o = data_q[w_lk_set][w_lk_way];
                        w_touch_en  = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL, S_WRITE: begin
                if (inval_i) inval_pend_d = 1'b1;
                if (mem_ack_i) begin
                    cpu_ready_o  = 1'b1;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    state_d      = S_IDLE;
                    inval_pend_d = 1'b0;
                    w_clear_all  = inval_pend_q || inval_i;
                    if (state_q == S_FILL) begin
                        cpu_rdata_o  = mem_rdata_i;
                        w_install_en = 1'b1;
                        w_touch_en   = 1'b1;
                        w_touch_set  = w_fl_set;
                        w_touch_way  = w_victim;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        w_touch_age = age_q[w_touch_set][w_touch_way];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inval_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inval_pend_q <= inval_pend_d;
        end
    end

    // Valid bits and LRU ages; a clear issued on the same edge as a fill overrides the install.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            if (w_install_en) valid_q[w_fl_set][w_victim] <= 1'b1;
            if (w_touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == w_touch_way)
                        age_q[w_touch_set][w] <= '0;
                    else if (age_q[w_touch_set][w] < w_touch_age)
                        age_q[w_touch_set][w] <= age_q[w_touch_set][w] + 1'b1;
                end
            end
            if (w_clear_all) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_install_en) begin
            tag_q[w_fl_set][w_victim]  <= w_fl_tag;
            data_q[w_fl_set][w_victim] <= mem_rdata_i;
        end
        if (w_store_en) data_q[w_lk_set][w_lk_way] <= cpu_wdata_i;
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
// ============================================================================
// Module  : tb_set_assoc_cache
// Brief   : Directed + random bench; reference keeps resident addresses with
//           last-use stamps per set and a word memory image.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_set_assoc_cache;

    localparam int WAYS = 2;
    localparam int SW   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0, inval_i = 1'b0, mem_ack_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0, mem_rdata_i = '0;
    logic [31:0] cpu_rdata_o, mem_addr_o, mem_wdata_o;
    logic        cpu_ready_o, hit_o, mem_req_o, mem_we_o;

    int tests = 0;
    int fails = 0;

    int unsigned cached [logic [31:0]];
    logic [31:0] mem_m  [logic [31:0]];
    int unsigned stamp = 0;

    set_assoc_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SET_WIDTH(SW), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
        .hit_o(hit_o), .inval_i(inval_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int set_of(logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << SW) - 1));
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (!mem_m.exists(a)) mem_m[a] = $urandom;
        return mem_m[a];
    endfunction

    function automatic void touch(logic [31:0] a);
        stamp++;
        cached[a] = stamp;
    endfunction

    // Full set: drop the least recently used resident address of that set.
    function automatic void install(logic [31:0] a);
        int          cnt = 0;
        int unsigned oldest = 32'hFFFF_FFFF;
        logic [31:0] old = '0;
        foreach (cached[k]) begin
            if (set_of(k) == set_of(a)) begin
                cnt++;
                if (cached[k] < oldest) begin
                    oldest = cached[k];
                    old    = k;
                end
            end
        end
        if (cnt >= WAYS) cached.delete(old);
        touch(a);
    endfunction

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int dly, input bit inv_mid, output bit was_hit);
        bit exp_hit;
        exp_hit     = !we && cached.exists(a) && !inval_i;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = a;
        cpu_wdata_i = wd;
        @(negedge clk);
        was_hit = hit_o;
        chk("hit_o", {31'd0, hit_o}, {31'd0, exp_hit});
        if (exp_hit) begin
            chk("hit ready", {31'd0, cpu_ready_o}, 32'd1);
            chk("hit rdata", cpu_rdata_o, mem_rd(a));
            touch(a);
            @(posedge clk); #1;
            cpu_req_i = 1'b0;
            return;
        end
        chk("idle ready", {31'd0, cpu_ready_o}, 32'd0);
        if (inval_i) cached.delete();
        @(posedge clk); #1;
        inval_i = inv_mid;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("wait req", {31'd0, mem_req_o}, 32'd1);
            chk("wait we", {31'd0, mem_we_o}, {31'd0, we});
            chk("wait addr", mem_addr_o, a);
            if (we) chk("wait wdata", mem_wdata_o, wd);
            chk("wait ready", {31'd0, cpu_ready_o}, 32'd0);
            @(posedge clk); #1;
            inval_i = 1'b0;
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = we ? $urandom : mem_rd(a);
        @(negedge clk);
        chk("ack req", {31'd0, mem_req_o}, 32'd1);
        chk("ack addr", mem_addr_o, a);
        chk("ack ready", {31'd0, cpu_ready_o}, 32'd1);
        if (!we) chk("fill rdata", cpu_rdata_o, mem_rd(a));
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        inval_i   = 1'b0;
        cpu_req_i = 1'b0;
        if (we) begin
            mem_m[a] = wd;
            if (cached.exists(a)) touch(a);
        end else begin
            install(a);
        end
        if (inv_mid) cached.delete();
    endtask

    task automatic idle_chk();
        cpu_req_i = 1'b0;
        @(negedge clk);
        chk("idle ready", {31'd0, cpu_ready_o}, 32'd0);
        chk("idle rdata", cpu_rdata_o, 32'd0);
        chk("idle hit", {31'd0, hit_o}, 32'd0);
        chk("idle mem_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_inval();
        inval_i = 1'b1;
        @(posedge clk); #1;
        inval_i = 1'b0;
        cached.delete();
    endtask

    initial begin
        bit          h;
        logic [31:0] a;
        int          r;
        // Reset state
        @(negedge clk);
        chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst mem_addr", mem_addr_o, 32'd0);
        chk("rst mem_wdata", mem_wdata_o, 32'd0);
        chk("rst ready", {31'd0, cpu_ready_o}, 32'd0);
        chk("rst hit", {31'd0, hit_o}, 32'd0);
        chk("rst rdata", cpu_rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_chk();

        // Miss then zero-latency hit
        mem_m[32'h100] = 32'hDEAD_BEEF;
        access(1'b0, 32'h100, 0, 1, 1'b0, h);
        chk("t1 first miss", {31'd0, h}, 32'd0);
        access(1'b0, 32'h100, 0, 0, 1'b0, h);
        chk("t1 reload hit", {31'd0, h}, 32'd1);

        // Load coinciding with invalidate is a miss
        inval_i = 1'b1;
        access(1'b0, 32'h100, 0, 0, 1'b0, h);
        chk("inval+load miss", {31'd0, h}, 32'd0);

        // LRU eviction within set 0
        access(1'b0, 32'h000, 0, 0, 1'b0, h);
        access(1'b0, 32'h020, 0, 1, 1'b0, h);
        access(1'b0, 32'h000, 0, 0, 1'b0, h);
        chk("t2 0x000 hit", {31'd0, h}, 32'd1);
        access(1'b0, 32'h040, 0, 0, 1'b0, h);
        access(1'b0, 32'h000, 0, 0, 1'b0, h);
        chk("t2 0x000 still hit", {31'd0, h}, 32'd1);
        access(1'b0, 32'h040, 0, 0, 1'b0, h);
        chk("t2 0x040 hit", {31'd0, h}, 32'd1);
        access(1'b0, 32'h020, 0, 0, 1'b0, h);
        chk("t2 0x020 evicted", {31'd0, h}, 32'd0);

        // Write-through store hit and no-allocate store miss
        access(1'b0, 32'h100, 0, 0, 1'b0, h);
        access(1'b1, 32'h100, 32'h11, 1, 1'b0, h);
        access(1'b0, 32'h100, 0, 0, 1'b0, h);
        chk("t3 store hit data", {31'd0, h}, 32'd1);
        access(1'b1, 32'h200, 32'h22, 0, 1'b0, h);
        access(1'b0, 32'h200, 0, 0, 1'b0, h);
        chk("t3 no allocate", {31'd0, h}, 32'd0);

        // Invalidate during a fill
        access(1'b0, 32'h300, 0, 2, 1'b1, h);
        access(1'b0, 32'h300, 0, 0, 1'b0, h);
        chk("t4 0x300 miss", {31'd0, h}, 32'd0);
        access(1'b0, 32'h200, 0, 0, 1'b0, h);
        chk("t4 0x200 miss", {31'd0, h}, 32'd0);

        // Asynchronous reset abandons a fill
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0F0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5 req before rst", {31'd0, mem_req_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5 async req", {31'd0, mem_req_o}, 32'd0);
        chk("t5 async addr", mem_addr_o, 32'd0);
        cpu_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cached.delete();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        chk("t5 stray ack", {31'd0, cpu_ready_o}, 32'd0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        access(1'b0, 32'h0F0, 0, 0, 1'b0, h);
        chk("t5 reload miss", {31'd0, h}, 32'd0);

        // Long write stall
        access(1'b1, 32'h104, 32'hCAFE_0104, 20, 1'b0, h);
        idle_chk();

        // Random traffic over two sets with four tags each
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 1) << 2);
            r = $urandom_range(0, 99);
            if (r < 5) do_inval();
            else if (r < 30) access(1'b1, a, $urandom, $urandom_range(0, 2), r < 8, h);
            else access(1'b0, a, 0, $urandom_range(0, 2), r > 96, h);
            if (r >= 8 && r < 10) idle_chk();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
